// File: rtl/serial_queue_pkg.sv
// serial_queue_pkg: byte width and deserializer states shared by the serial queue.
package serial_queue_pkg;
    localparam int BYTE_W = 8;
    typedef enum logic [2:0] {IDLE, ALIGN, SHIFT, COMMIT, WAIT_RELEASE} deser_state_t;
endpackage

// File: rtl/queue_mem.sv
// queue_mem: DEPTH x byte register file, synchronous write, combinational read, no storage reset.
module queue_mem
    import serial_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [BYTE_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [BYTE_W-1:0] o_rdata
);
    logic [BYTE_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/serial_queue_ctrl.sv
// serial_queue_ctrl: synchronizes serial pins, deserializes MSB-first bytes and
// arbitrates push/pop on an 8-deep byte queue with occupancy and error flags.
module serial_queue_ctrl
    import serial_queue_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int BIT_CYCLES = 10
) (
    input  logic                       clock1M,
    input  logic                       reset,
    input  logic                       data_in,
    input  logic                       write_in,
    input  logic                       dequeue_in,
    output logic [BYTE_W-1:0]          data_out,
    output logic                       status_out,
    output logic                       empty_out,
    output logic [$clog2(DEPTH+1)-1:0] count_out,
    output logic                       overflow_out,
    output logic                       underflow_out
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(BIT_CYCLES);

    logic [1:0]        r_din_s, r_wr_s, r_dq_s;
    logic              r_wr_d, r_dq_d;
    deser_state_t      r_state, w_state_nxt;
    logic [TW-1:0]     r_tmr, w_tmr_nxt;
    logic [2:0]        r_bits, w_bits_nxt;
    logic [BYTE_W-1:0] r_shift, w_shift_nxt, w_head;
    logic [AW-1:0]     r_wptr, r_rptr;
    logic [CW-1:0]     r_count, w_count_nxt;
    logic              w_din, w_wr, w_wr_rise, w_sample;
    logic              w_push, w_pop, w_full, w_empty, w_push_ok, w_pop_ok;

    assign w_din     = r_din_s[1];
    assign w_wr      = r_wr_s[1];
    assign w_wr_rise = w_wr & ~r_wr_d;
    assign w_pop     = r_dq_s[1] & ~r_dq_d;
    assign w_push    = (r_state == COMMIT);

    // First sample closes ALIGN so samples land BIT_CYCLES/2 + k*BIT_CYCLES after the rise.
    always_comb begin
        w_sample    = (r_state == ALIGN && r_tmr == TW'(BIT_CYCLES / 2 - 2)) ||
                      (r_state == SHIFT && r_tmr == TW'(BIT_CYCLES - 1));
        w_state_nxt = r_state;
        w_tmr_nxt   = r_tmr + 1'b1;
        w_bits_nxt  = r_bits;
        w_shift_nxt = r_shift;
        case (r_state)
            IDLE: begin
                w_tmr_nxt   = '0;
                w_bits_nxt  = '0;
                w_state_nxt = w_wr_rise ? ALIGN : IDLE;
            end
            ALIGN, SHIFT: begin
                if (!w_wr) begin
                    w_state_nxt = IDLE;
                end else if (w_sample) begin
                    w_tmr_nxt   = '0;
                    w_bits_nxt  = r_bits + 1'b1;
                    w_shift_nxt = {r_shift[BYTE_W-2:0], w_din};
                    w_state_nxt = (r_bits == 3'(BYTE_W - 1)) ? COMMIT : SHIFT;
                end
            end
            COMMIT:       w_state_nxt = WAIT_RELEASE;
            WAIT_RELEASE: w_state_nxt = w_wr ? WAIT_RELEASE : IDLE;
            default:      w_state_nxt = IDLE;
        endcase
    end

    // A full queue still takes a push when a pop frees the head slot in the same cycle.
    assign w_full      = (r_count == CW'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_pop_ok    = w_pop & ~w_empty;
    assign w_push_ok   = w_push & (~w_full | w_pop_ok);
    assign w_count_nxt = r_count + CW'(w_push_ok) - CW'(w_pop_ok);
    assign count_out   = r_count;

    always_ff @(posedge clock1M or negedge reset) begin
        if (!reset) begin
            r_din_s       <= '0;
            r_wr_s        <= '0;
            r_dq_s        <= '0;
            r_wr_d        <= 1'b0;
            r_dq_d        <= 1'b0;
            r_state       <= IDLE;
            r_tmr         <= '0;
            r_bits        <= '0;
            r_shift       <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_count       <= '0;
            data_out      <= '0;
            status_out    <= 1'b0;
            empty_out     <= 1'b1;
            overflow_out  <= 1'b0;
            underflow_out <= 1'b0;
        end else begin
            r_din_s       <= {r_din_s[0], data_in};
            r_wr_s        <= {r_wr_s[0], write_in};
            r_dq_s        <= {r_dq_s[0], dequeue_in};
            r_wr_d        <= w_wr;
            r_dq_d        <= r_dq_s[1];
            r_state       <= w_state_nxt;
            r_tmr         <= w_tmr_nxt;
            r_bits        <= w_bits_nxt;
            r_shift       <= w_shift_nxt;
            r_wptr        <= r_wptr + AW'(w_push_ok);
            r_rptr        <= r_rptr + AW'(w_pop_ok);
            r_count       <= w_count_nxt;
            data_out      <= w_pop_ok ? w_head : data_out;
            status_out    <= (w_count_nxt == CW'(DEPTH));
            empty_out     <= (w_count_nxt == '0);
            overflow_out  <= w_push & w_full & ~w_pop;
            underflow_out <= w_pop & w_empty;
        end
    end

    queue_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
        .i_clk   (clock1M),
        .i_we    (w_push_ok),
        .i_waddr (r_wptr),
        .i_wdata (r_shift),
        .i_raddr (r_rptr),
        .o_rdata (w_head)
    );
endmodule

// File: tb/tb_serial_queue_ctrl.sv
`timescale 1ns/1ps
// tb_serial_queue_ctrl: directed frames and pops against a byte scoreboard for serial_queue_ctrl.
module tb_serial_queue_ctrl;
    localparam int DEPTH = 8;
    localparam int BITC  = 10;

    logic       clk = 1'b0, rst_n = 1'b0, din = 1'b0, wr = 1'b0, deq = 1'b0;
    logic [7:0] data_out;
    logic [3:0] count_out;
    logic       status_out, empty_out, overflow_out, underflow_out;
    int         checks = 0, errors = 0;
    int         ovf_seen = 0, unf_seen = 0, ovf_exp = 0, unf_exp = 0;
    logic [7:0] sb[$];
    logic [7:0] last_out = 8'h00;

    serial_queue_ctrl #(.DEPTH(DEPTH), .BIT_CYCLES(BITC)) dut (
        .clock1M       (clk),
        .reset         (rst_n),
        .data_in       (din),
        .write_in      (wr),
        .dequeue_in    (deq),
        .data_out      (data_out),
        .status_out    (status_out),
        .empty_out     (empty_out),
        .count_out     (count_out),
        .overflow_out  (overflow_out),
        .underflow_out (underflow_out)
    );

    always #500 clk = ~clk;

    always @(negedge clk) begin
        if (overflow_out === 1'b1) ovf_seen++;
        if (underflow_out === 1'b1) unf_seen++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Full frames with no overlapping pop update the scoreboard; partial or pop-timed frames are modelled by the caller.
    task automatic send_frame(input logic [7:0] b, input int nbits = 8, input int pop_at = -1);
        logic [7:0] v;
        v = b;
        if (nbits == 8 && pop_at < 0) begin
            if (sb.size() < DEPTH) sb.push_back(v);
            else ovf_exp++;
        end
        wr = 1'b1;
        for (int c = 0; c < nbits * BITC; c++) begin
            din = v[7 - c / BITC];
            if (c == pop_at) deq = 1'b1;
            @(negedge clk);
        end
        wr  = 1'b0;
        din = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic pop_check(input string tag);
        if (sb.size() > 0) last_out = sb.pop_front();
        else unf_exp++;
        deq = 1'b1;
        repeat (100) @(negedge clk);
        deq = 1'b0;
        repeat (5) @(negedge clk);
        check({tag, " data"}, 32'(data_out), 32'(last_out));
        check({tag, " count"}, 32'(count_out), sb.size());
        check({tag, " underflow"}, unf_seen, unf_exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " data"}, 32'(data_out), 32'h00);
        check({tag, " count"}, 32'(count_out), 32'd0);
        check({tag, " full"}, 32'(status_out), 32'd0);
        check({tag, " empty"}, 32'(empty_out), 32'd1);
        check({tag, " ovf"}, 32'(overflow_out), 32'd0);
        check({tag, " unf"}, 32'(underflow_out), 32'd0);
    endtask

    initial begin
        logic [7:0] fill [8];
        fill = '{8'h33, 8'h55, 8'h99, 8'hFF, 8'h11, 8'h22, 8'h44, 8'h88};
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        send_frame(8'hAA);
        send_frame(8'hCC);
        send_frame(8'hF0);
        send_frame(8'h0F);
        check("fill4 count", 32'(count_out), 32'd4);
        check("fill4 empty", 32'(empty_out), 32'd0);
        check("fill4 full", 32'(status_out), 32'd0);
        for (int i = 0; i < 4; i++) pop_check($sformatf("pop4_%0d", i));
        check("drain4 empty", 32'(empty_out), 32'd1);

        for (int i = 0; i < 8; i++) send_frame(fill[i]);
        check("fill8 full", 32'(status_out), 32'd1);
        check("fill8 count", 32'(count_out), 32'd8);
        send_frame(8'h00);
        check("ovf pulses", ovf_seen, ovf_exp);
        check("ovf count", 32'(count_out), 32'd8);
        for (int i = 0; i < 9; i++) pop_check($sformatf("pop9_%0d", i));
        check("drain9 empty", 32'(empty_out), 32'd1);

        for (int i = 0; i < 8; i++) send_frame(8'(i + 1));
        check("refill full", 32'(status_out), 32'd1);
        send_frame(8'hE7, 8, 75);
        deq = 1'b0;
        last_out = sb.pop_front();
        sb.push_back(8'hE7);
        repeat (5) @(negedge clk);
        check("both data", 32'(data_out), 32'(last_out));
        check("both count", 32'(count_out), 32'd8);
        check("both ovf", ovf_seen, ovf_exp);
        check("both full", 32'(status_out), 32'd1);
        for (int i = 0; i < 8; i++) pop_check($sformatf("popboth_%0d", i));

        send_frame(8'hFF, 5);
        check("abort count", 32'(count_out), 32'd0);
        check("abort ovf", ovf_seen, ovf_exp);

        send_frame(8'h12);
        send_frame(8'h34);
        send_frame(8'h56);
        check("pre-reset count", 32'(count_out), 32'd3);
        wr  = 1'b1;
        din = 1'b1;
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async reset");
        repeat (2) @(negedge clk);
        wr  = 1'b0;
        din = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("held reset");
        rst_n = 1'b1;
        sb.delete();
        last_out = 8'h00;
        repeat (3) @(negedge clk);
        send_frame(8'h5A);
        check("post-reset count", 32'(count_out), 32'd1);
        pop_check("post-reset pop");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
